// File: rtl/imem_program_loader.sv
// Byte-stream instruction-memory loader: length header, big-endian payload words, XOR checksum.
// Holds the CPU stalled until a verified load completes.
module imem_program_loader #(
  parameter int ADDR_BASE = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        resetManual,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  input  logic        start,
  output logic        imemWrite,
  output logic [31:0] imemAddr,
  output logic [31:0] imemData,
  output logic        cpuHold,
  output logic        loadDone,
  output logic        loadError,
  output logic [2:0]  dbgState
);

  // Handshake: a byte transfers on a rising edge where byteValid && byteReady;
  // byteReady never depends on byteValid, and nothing else advances the loader.

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [31:0] BASE_ADDR = 32'(ADDR_BASE);
  localparam logic [31:0] MAX_W     = 32'(MAX_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_count_hi;
  logic [15:0] r_count;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  logic [7:0]  r_acc;
  logic [15:0] r_word_idx;
  logic        r_byte_ready;
  logic        r_imem_write;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_data;
  logic        r_cpu_hold;
  logic        r_load_done;
  logic        r_load_error;

  logic        w_accept;
  logic [15:0] w_count;

  assign w_accept = byteValid && r_byte_ready;
  assign w_count  = {r_count_hi, byteIn};

  always_ff @(posedge clk or negedge resetManual) begin
    if (!resetManual) r_state <= S_HDR0;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR0:  if (w_accept) w_next = S_HDR1;
      S_HDR1: begin
        if (w_accept) begin
          if ({16'd0, w_count} > MAX_W) w_next = S_ERROR;
          else if (w_count == 16'd0)    w_next = S_CHECK;
          else                          w_next = S_LOAD;
        end
      end
      S_LOAD:  if (w_accept && r_byte_cnt == 2'd3) w_next = S_WRITE;
      S_WRITE: w_next = (r_word_idx + 16'd1 == r_count) ? S_CHECK : S_LOAD;
      S_CHECK: if (w_accept) w_next = (byteIn == r_acc) ? S_DONE : S_ERROR;
      S_DONE:  if (start) w_next = S_HDR0;
      S_ERROR: if (start) w_next = S_HDR0;
      default: w_next = S_HDR0;
    endcase
  end

  // Status outputs are registered from the next state so they are glitch-free
  // and byteReady stays low while reset is held.
  always_ff @(posedge clk or negedge resetManual) begin
    if (!resetManual) begin
      r_count_hi   <= 8'd0;
      r_count      <= 16'd0;
      r_byte_cnt   <= 2'd0;
      r_shift      <= 24'd0;
      r_acc        <= 8'd0;
      r_word_idx   <= 16'd0;
      r_byte_ready <= 1'b0;
      r_imem_write <= 1'b0;
      r_imem_addr  <= 32'd0;
      r_imem_data  <= 32'd0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_imem_write <= (w_next == S_WRITE);
      r_byte_ready <= (w_next == S_HDR0) || (w_next == S_HDR1) ||
                      (w_next == S_LOAD) || (w_next == S_CHECK);
      r_cpu_hold   <= (w_next != S_DONE);
      r_load_done  <= (w_next == S_DONE);
      r_load_error <= (w_next == S_ERROR);
      case (r_state)
        S_HDR0: if (w_accept) r_count_hi <= byteIn;
        S_HDR1: if (w_accept) r_count <= w_count;
        S_LOAD: begin
          if (w_accept) begin
            r_shift    <= {r_shift[15:0], byteIn};
            r_acc      <= r_acc ^ byteIn;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_imem_data <= {r_shift, byteIn};
              r_imem_addr <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
            end
          end
        end
        S_WRITE: r_word_idx <= r_word_idx + 16'd1;
        S_DONE, S_ERROR: begin
          if (start) begin
            r_word_idx <= 16'd0;
            r_acc      <= 8'd0;
            r_byte_cnt <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign byteReady = r_byte_ready;
  assign imemWrite = r_imem_write;
  assign imemAddr  = r_imem_addr;
  assign imemData  = r_imem_data;
  assign cpuHold   = r_cpu_hold;
  assign loadDone  = r_load_done;
  assign loadError = r_load_error;
  assign dbgState  = r_state;

endmodule
